boid_frame_scheduler: RTL and testbench
=======================================

BOID_FRAME_SCHEDULER -- requirements
Module: boid_frame_scheduler

Interface
REQ-001 Parameter MAX_BOIDS, default 8, number of BPU slots scanned per frame (power of two, 2..32).
REQ-002 Parameter VIDEO_WIDTH, default 640, pixels per line.
REQ-003 Parameter VIDEO_HEIGHT, default 480, lines per frame.
REQ-004 Parameter PIXEL_ADDRESS_WIDTH, default 19, display RAM address width.
REQ-005 The block SHALL use one clock, `clock`, and an asynchronous active-low reset, `resetn`.
REQ-006 `clock`  in  1  system clock, 50 MHz domain.
REQ-007 `resetn`  in  1  asynchronous active-low reset.
REQ-008 `screen_end`  in  1  VGA end-of-frame pulse, sampled on `clock`.
REQ-009 `boid_x`  in  10  x of the BPU addressed by `boid_sel`, valid in the same cycle.
REQ-010 `boid_y`  in  9  y of the BPU addressed by `boid_sel`, valid in the same cycle.
REQ-011 `boid_sel`  out  clog2(MAX_BOIDS)  index of the BPU being read.
REQ-012 `disp_clear`  out  1  one-cycle pulse that swaps the display RAM to a cleared bank.
REQ-013 `disp_we`  out  1  display RAM write enable (write data is constant 1).
REQ-014 `disp_addr`  out  PIXEL_ADDRESS_WIDTH  display RAM write address.
REQ-015 `busy`  out  1  high whenever state != IDLE.
REQ-016 `frame_done`  out  1  one-cycle pulse when a scan completes.
REQ-017 `overrun`  out  1  sticky flag set when `screen_end` arrives while busy.
REQ-018 `clip_count`  out  8  saturating count of suppressed writes in the last frame.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, SCAN, DRAIN and DONE.
REQ-020 In IDLE with `screen_end`=1, the next state SHALL be CLEAR; otherwise the FSM SHALL remain in IDLE.
REQ-021 CLEAR SHALL last exactly 1 cycle with `disp_clear`=1, zero the index counter and `clip_count`, then go to SCAN.
REQ-022 SCAN SHALL drive `boid_sel`=0..MAX_BOIDS-1 on consecutive cycles, one index per cycle, then go to DRAIN.
REQ-023 Address stage SHALL register `boid_x`+VIDEO_WIDTH*`boid_y`, computed at PIXEL_ADDRESS_WIDTH bits, into `disp_addr`; `disp_we` SHALL assert exactly 1 cycle after the corresponding `boid_sel`.
REQ-024 DRAIN SHALL last 1 cycle and carry the final write; DONE SHALL last 1 cycle with `frame_done`=1, then go to IDLE.
REQ-025 Latency SHALL be exactly MAX_BOIDS+3 cycles from the IDLE cycle sampling `screen_end` to `frame_done`; `disp_we`=0 in IDLE, CLEAR and DONE.
REQ-026 `boid_sel` SHALL be 0 and `disp_we`=0 outside SCAN/DRAIN, and `disp_clear`=0 outside CLEAR.
REQ-027 `screen_end` sampled in any state other than IDLE SHALL be ignored for sequencing and SHALL set `overrun`; only reset clears `overrun`.
REQ-028 A `screen_end` held high for several cycles SHALL start exactly one scan per IDLE sample, so a pulse still high in the cycle after DONE starts a new scan.
REQ-029 `clip_count` SHALL saturate at 255 and hold its value until the next CLEAR.

Reset
REQ-030 Asserting `resetn` low SHALL immediately force IDLE, with every output 0 and the index, address and clip registers cleared.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a `frame_done` pulse; the FSM SHALL leave IDLE only on a `screen_end` sampled after reset release.

Configuration
REQ-032 With macro BOID_CLIP_EN defined, a coordinate with x>=VIDEO_WIDTH or y>=VIDEO_HEIGHT SHALL suppress its `disp_we` and increment `clip_count`.
REQ-033 Without BOID_CLIP_EN, every scanned boid SHALL be written with its truncated address, and `clip_count` SHALL be tied to 0.

Structure
REQ-034 The state encoding, VIDEO_WIDTH/VIDEO_HEIGHT defaults and the pixel address width SHALL live in the shared package boid_pkg.
REQ-035 The address computation and clip compare SHALL be one sub-module, boid_pixel_addr, containing the registered stage.

Verification
REQ-036 Bench: reset, MAX_BOIDS=8, 1-cycle `screen_end` -> `disp_clear` at cycle 1, `boid_sel` 0..7 at cycles 2..9, `disp_we` at cycles 3..10, `frame_done` at cycle 11.
REQ-037 Bench: boid 3 at (10,20) -> `disp_we` with `disp_addr`=12810 exactly 1 cycle after `boid_sel`=3.
REQ-038 Bench: `screen_end` at cycle 5 of a scan -> no restart, `overrun`=1, `frame_done` still at cycle 11.
REQ-039 Bench: BOID_CLIP_EN, boid 2 at (640,0), boid 5 at (0,480) -> those two writes suppressed, `clip_count`=2; without the macro -> 8 writes, `clip_count`=0.
REQ-040 Bench: `resetn` low at cycle 6 of a scan -> all outputs 0 at once, no `frame_done`, IDLE until the next `screen_end`.
REQ-041 Bench: `screen_end` held high for 20 cycles -> a second scan starts in the cycle after the first `frame_done`, and `overrun`=1.

Source files
------------

// File: rtl/boid_pkg.sv
// Shared definitions for the boid frame scheduler: scheduler state encoding,
// default video geometry, display RAM address width and small helpers.
package boid_pkg;

    localparam int VIDEO_WIDTH_C         = 640;
    localparam int VIDEO_HEIGHT_C        = 480;
    localparam int PIXEL_ADDRESS_WIDTH_C = 19;
    localparam int COORD_X_WIDTH_C       = 10;
    localparam int COORD_Y_WIDTH_C       = 9;
    localparam int CLIP_COUNT_WIDTH_C    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CLIP_COUNT_WIDTH_C-1:0] clip_sat_inc(
        input logic [CLIP_COUNT_WIDTH_C-1:0] value
    );
        if (value == 8'd255) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/boid_pixel_addr.sv
// Registered pixel-address stage: turns the (x, y) of the boid being read into
// a linear display RAM address and write strobe one cycle later.
// Optional macro BOID_CLIP_EN: off-screen coordinates suppress the write and
// are counted in a saturating per-frame clip counter; without it every scanned
// boid is written with its truncated address and the counter reads 0.
module boid_pixel_addr
    import boid_pkg::*;
#(
    parameter int VIDEO_WIDTH         = VIDEO_WIDTH_C,
    parameter int VIDEO_HEIGHT        = VIDEO_HEIGHT_C,
    parameter int PIXEL_ADDRESS_WIDTH = PIXEL_ADDRESS_WIDTH_C
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           valid_i,
    input  logic                           clear_i,
    input  logic [COORD_X_WIDTH_C-1:0]     x_i,
    input  logic [COORD_Y_WIDTH_C-1:0]     y_i,
    output logic                           we_o,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] addr_o,
    output logic [CLIP_COUNT_WIDTH_C-1:0]  clip_count_o
);

`ifdef BOID_CLIP_EN
    localparam logic CLIP_EN_C = 1'b1;
`else
    localparam logic CLIP_EN_C = 1'b0;
`endif

    localparam logic [PIXEL_ADDRESS_WIDTH-1:0] LINE_PITCH_C = PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);
    localparam logic [31:0] X_LIMIT_C = 32'(VIDEO_WIDTH);
    localparam logic [31:0] Y_LIMIT_C = 32'(VIDEO_HEIGHT);

    logic [PIXEL_ADDRESS_WIDTH-1:0] addr_s;
    logic                           off_screen_s;
    logic                           clip_s;
    logic                           we_d, we_q;
    logic [PIXEL_ADDRESS_WIDTH-1:0] addr_d, addr_q;
    logic [CLIP_COUNT_WIDTH_C-1:0]  clip_d, clip_q;

    // Linear address and off-screen test for the coordinate presented this cycle.
    always_comb begin
        addr_s       = PIXEL_ADDRESS_WIDTH'(x_i) + LINE_PITCH_C * PIXEL_ADDRESS_WIDTH'(y_i);
        off_screen_s = ({22'd0, x_i} >= X_LIMIT_C) || ({23'd0, y_i} >= Y_LIMIT_C);
        clip_s       = CLIP_EN_C & off_screen_s;
    end

    // Next write strobe/address; the address rests at 0 between scans.
    always_comb begin
        we_d = valid_i & ~clip_s;
        if (valid_i) begin
            addr_d = addr_s;
        end else begin
            addr_d = {PIXEL_ADDRESS_WIDTH{1'b0}};
        end
    end

    // Next clip count: cleared at frame start, saturating bump per suppressed write.
    always_comb begin
        clip_d = clip_q;
        if (clear_i) begin
            clip_d = 8'd0;
        end else if (valid_i && clip_s) begin
            clip_d = clip_sat_inc(clip_q);
        end else begin
            clip_d = clip_q;
        end
    end

    // Address stage and clip counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            we_q   <= 1'b0;
            addr_q <= {PIXEL_ADDRESS_WIDTH{1'b0}};
            clip_q <= 8'd0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            clip_q <= clip_d;
        end
    end

    assign we_o         = we_q;
    assign addr_o       = addr_q;
    assign clip_count_o = CLIP_EN_C ? clip_q : 8'd0;

endmodule

// File: rtl/boid_frame_scheduler.sv
// Boid frame scheduler: on each VGA end-of-frame pulse, swaps in a cleared
// display bank, reads every BPU slot once and writes one pixel per boid.
// Optional macro BOID_CLIP_EN enables off-screen write suppression and the
// clip counter (see boid_pixel_addr).
module boid_frame_scheduler
    import boid_pkg::*;
#(
    parameter int MAX_BOIDS           = 8,
    parameter int VIDEO_WIDTH         = VIDEO_WIDTH_C,
    parameter int VIDEO_HEIGHT        = VIDEO_HEIGHT_C,
    parameter int PIXEL_ADDRESS_WIDTH = PIXEL_ADDRESS_WIDTH_C
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           screen_end,
    input  logic [COORD_X_WIDTH_C-1:0]     boid_x,
    input  logic [COORD_Y_WIDTH_C-1:0]     boid_y,
    output logic [$clog2(MAX_BOIDS)-1:0]   boid_sel,
    output logic                           disp_clear,
    output logic                           disp_we,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] disp_addr,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun,
    output logic [CLIP_COUNT_WIDTH_C-1:0]  clip_count
);

    localparam int SEL_W = $clog2(MAX_BOIDS);
    localparam logic [SEL_W-1:0] LAST_IDX_C = SEL_W'(MAX_BOIDS - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             disp_clear_q, disp_clear_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic             scan_valid_s;
    logic             clip_clear_s;

    // State register plus the registered outputs decoded from the next state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idx_q        <= {SEL_W{1'b0}};
            disp_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            disp_clear_q <= disp_clear_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state: one pass IDLE -> CLEAR -> SCAN x MAX_BOIDS -> DRAIN -> DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (screen_end) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = ST_SCAN;
            ST_SCAN: begin
                if (idx_q == LAST_IDX_C) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode: index advances only while staying in SCAN, so it is 0
    // on the first scan cycle and everywhere outside SCAN.
    always_comb begin
        disp_clear_d = (state_d == ST_CLEAR);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
        if ((state_q == ST_SCAN) && (state_d == ST_SCAN)) begin
            idx_d = idx_q + SEL_W'(1);
        end else begin
            idx_d = {SEL_W{1'b0}};
        end
        overrun_d = overrun_q | (screen_end & (state_q != ST_IDLE));
    end

    assign scan_valid_s = (state_q == ST_SCAN);
    assign clip_clear_s = (state_d == ST_CLEAR);

    boid_pixel_addr #(
        .VIDEO_WIDTH         (VIDEO_WIDTH),
        .VIDEO_HEIGHT        (VIDEO_HEIGHT),
        .PIXEL_ADDRESS_WIDTH (PIXEL_ADDRESS_WIDTH)
    ) u_pixel_addr (
        .clock        (clock),
        .resetn       (resetn),
        .valid_i      (scan_valid_s),
        .clear_i      (clip_clear_s),
        .x_i          (boid_x),
        .y_i          (boid_y),
        .we_o         (disp_we),
        .addr_o       (disp_addr),
        .clip_count_o (clip_count)
    );

    assign boid_sel   = idx_q;
    assign disp_clear = disp_clear_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Self-checking bench for boid_frame_scheduler (MAX_BOIDS = 8, 640x480).
// A timeline model (cycle offset since the accepted screen_end) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_boid_frame_scheduler;

    localparam int M = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic        screen_end;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic [2:0]  boid_sel;
    logic        disp_clear;
    logic        disp_we;
    logic [18:0] disp_addr;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [7:0]  clip_count;

    logic [9:0] bx [M];
    logic [8:0] by [M];

    int total = 0;
    int bad   = 0;

    // Per-cycle logs of one run (cycle 0 = the cycle screen_end is first sampled).
    int clr_l [40];
    int sel_l [40];
    int we_l  [40];
    int adr_l [40];
    int fd_l  [40];
    int bsy_l [40];
    int ovr_l [40];
    int clp_l [40];

    always #5 clock = ~clock;

    // BPU array emulation: coordinates of the selected slot, same cycle.
    assign boid_x = bx[boid_sel];
    assign boid_y = by[boid_sel];

    boid_frame_scheduler dut (
        .clock      (clock),
        .resetn     (resetn),
        .screen_end (screen_end),
        .boid_x     (boid_x),
        .boid_y     (boid_y),
        .boid_sel   (boid_sel),
        .disp_clear (disp_clear),
        .disp_we    (disp_we),
        .disp_addr  (disp_addr),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .clip_count (clip_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit clipped(input int i);
`ifdef BOID_CLIP_EN
        return (bx[i] >= 10'd640) || (by[i] >= 9'd480);
`else
        return 1'b0;
`endif
    endfunction

    // Model: k_m = cycles since the IDLE cycle that accepted screen_end (-1 when idle).
    int         k_m   = -1;
    logic       ovr_m = 1'b0;
    logic [7:0] clip_m = 8'd0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            k_m    <= -1;
            ovr_m  <= 1'b0;
            clip_m <= 8'd0;
        end else if (k_m < 0) begin
            if (screen_end) begin
                k_m    <= 1;
                clip_m <= 8'd0;
            end
        end else begin
            if (screen_end) ovr_m <= 1'b1;
            if (k_m >= 2 && k_m <= M + 1 && clipped(k_m - 2) && clip_m != 8'd255)
                clip_m <= clip_m + 8'd1;
            k_m <= (k_m == M + 3) ? -1 : k_m + 1;
        end
    end

    // Compare process: every output against the model, every cycle.
    always @(negedge clock) begin
        int k;
        int i;
        int exp_we;
        int exp_addr;
        k        = k_m;
        exp_we   = 0;
        exp_addr = 0;
        if (k >= 3 && k <= M + 2) begin
            i        = k - 3;
            exp_we   = clipped(i) ? 0 : 1;
            exp_addr = (int'(bx[i]) + 640 * int'(by[i])) % 524288;
        end
        check("m_busy",       busy,       (k >= 1) ? 1 : 0);
        check("m_disp_clear", disp_clear, (k == 1) ? 1 : 0);
        check("m_boid_sel",   boid_sel,   (k >= 2 && k <= M + 1) ? k - 2 : 0);
        check("m_disp_we",    disp_we,    exp_we);
        check("m_disp_addr",  disp_addr,  exp_addr);
        check("m_frame_done", frame_done, (k == M + 3) ? 1 : 0);
        check("m_overrun",    overrun,    ovr_m);
        check("m_clip_count", clip_count, clip_m);
    end

    task automatic default_boids();
        for (int i = 0; i < M; i++) begin
            bx[i] = 10'(i * 5);
            by[i] = 9'(i * 3);
        end
        bx[3] = 10'd10;
        by[3] = 9'd20;
    endtask

    // Runs ncyc cycles from a drive point; screen_end follows se_mask per cycle,
    // resetn is pulled low for cycle rst_at (-1: never).
    task automatic run(input int ncyc, input logic [63:0] se_mask, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            screen_end = se_mask[c];
            resetn     = (c == rst_at) ? 1'b0 : 1'b1;
            if (c == rst_at) begin
                #1;
                check("rst_now_busy",  busy,       0);
                check("rst_now_sel",   boid_sel,   0);
                check("rst_now_we",    disp_we,    0);
                check("rst_now_addr",  disp_addr,  0);
                check("rst_now_clear", disp_clear, 0);
                check("rst_now_done",  frame_done, 0);
            end
            @(negedge clock);
            clr_l[c] = int'(disp_clear);
            sel_l[c] = int'(boid_sel);
            we_l[c]  = int'(disp_we);
            adr_l[c] = int'(disp_addr);
            fd_l[c]  = int'(frame_done);
            bsy_l[c] = int'(busy);
            ovr_l[c] = int'(overrun);
            clp_l[c] = int'(clip_count);
            @(posedge clock);
            #2;
        end
        screen_end = 1'b0;
        resetn     = 1'b1;
    endtask

    initial begin
        int n_we;
        int n_fd;
        int n_clr;
        int n_busy;
        int exp_we_n;
        int exp_clip;

        resetn     = 1'b0;
        screen_end = 1'b0;
        default_boids();
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;
        @(negedge clock);
        check("reset_busy",  busy,       0);
        check("reset_sel",   boid_sel,   0);
        check("reset_we",    disp_we,    0);
        check("reset_ovr",   overrun,    0);
        check("reset_done",  frame_done, 0);
        check("reset_clip",  clip_count, 0);
        @(posedge clock);
        #2;

        // Basic frame timeline and boid 3 at (10,20).
        run(14, 64'h1, -1);
        check("t1_clear_c0",  clr_l[0], 0);
        check("t1_clear_c1",  clr_l[1], 1);
        check("t1_clear_c2",  clr_l[2], 0);
        for (int c = 2; c <= 9; c++) check("t1_sel", sel_l[c], c - 2);
        check("t1_we_c2",     we_l[2], 0);
        check("t1_we_c3",     we_l[3], 1);
        check("t1_we_c10",    we_l[10], 1);
        check("t1_we_c11",    we_l[11], 0);
        check("t1_sel_b3",    sel_l[5], 3);
        check("t1_we_b3",     we_l[6], 1);
        check("t1_addr_b3",   adr_l[6], 12810);
        check("t1_done_c10",  fd_l[10], 0);
        check("t1_done_c11",  fd_l[11], 1);
        check("t1_done_c12",  fd_l[12], 0);
        check("t1_busy_c0",   bsy_l[0], 0);
        check("t1_busy_c1",   bsy_l[1], 1);
        check("t1_busy_c11",  bsy_l[11], 1);
        check("t1_busy_c12",  bsy_l[12], 0);
        check("t1_ovr",       ovr_l[13], 0);

        // screen_end again at cycle 5: ignored for sequencing, sets overrun.
        run(16, 64'h21, -1);
        n_fd = 0;
        n_clr = 0;
        for (int c = 0; c < 16; c++) begin
            n_fd  += fd_l[c];
            n_clr += clr_l[c];
        end
        check("t2_done_c11",  fd_l[11], 1);
        check("t2_done_cnt",  n_fd, 1);
        check("t2_clear_cnt", n_clr, 1);
        check("t2_ovr_c5",    ovr_l[5], 0);
        check("t2_ovr_c6",    ovr_l[6], 1);
        check("t2_ovr_c15",   ovr_l[15], 1);
        check("t2_busy_c13",  bsy_l[13], 0);

        // Off-screen boids 2 (640,0) and 5 (0,480).
        bx[2] = 10'd640; by[2] = 9'd0;
        bx[5] = 10'd0;   by[5] = 9'd480;
        run(14, 64'h1, -1);
        n_we = 0;
        for (int c = 0; c < 14; c++) n_we += we_l[c];
`ifdef BOID_CLIP_EN
        exp_we_n = 6;
        exp_clip = 2;
`else
        exp_we_n = 8;
        exp_clip = 0;
`endif
        check("t3_we_cnt",    n_we, exp_we_n);
        check("t3_clip",      clp_l[12], exp_clip);
        check("t3_we_b2",     we_l[5], (exp_clip == 0) ? 1 : 0);
        check("t3_we_b5",     we_l[8], (exp_clip == 0) ? 1 : 0);
        check("t3_addr_b5",   adr_l[8], 307200);
        default_boids();

        // Reset during cycle 6 of a scan.
        run(20, 64'h1, 6);
        n_fd = 0;
        n_busy = 0;
        for (int c = 0; c < 20; c++) n_fd += fd_l[c];
        for (int c = 6; c < 20; c++) n_busy += bsy_l[c];
        check("t4_busy_c5",   bsy_l[5], 1);
        check("t4_no_done",   n_fd, 0);
        check("t4_idle",      n_busy, 0);
        check("t4_ovr",       ovr_l[6], 0);
        run(14, 64'h1, -1);
        check("t4_restart_done", fd_l[11], 1);

        // screen_end held for 20 cycles after a fresh reset.
        run(2, 64'h0, 0);
        run(32, 64'hFFFFF, -1);
        n_fd = 0;
        n_clr = 0;
        n_we = 0;
        for (int c = 0; c < 32; c++) begin
            n_fd  += fd_l[c];
            n_clr += clr_l[c];
            n_we  += we_l[c];
        end
        check("t5_done_c11",  fd_l[11], 1);
        check("t5_done_c23",  fd_l[23], 1);
        check("t5_done_cnt",  n_fd, 2);
        check("t5_clear_c13", clr_l[13], 1);
        check("t5_clear_cnt", n_clr, 2);
        check("t5_we_cnt",    n_we, 16);
        check("t5_busy_c12",  bsy_l[12], 0);
        check("t5_busy_c13",  bsy_l[13], 1);
        check("t5_busy_c24",  bsy_l[24], 0);
        check("t5_sel_c21",   sel_l[21], 7);
        check("t5_ovr",       ovr_l[31], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
